// File: rtl/param_heap_pq.sv
// param_heap_pq: register-array binary-heap priority queue.
// One heap level is processed per clock. The root entry is always presented on
// o_data/o_payload. MAX_FIRST selects whether the largest or smallest key sits
// at the root.
//
// Handshake: o_ready is high only while the FSM is idle. A request (i_wrt
// and/or i_read) is taken on a rising edge where o_ready=1. Requests that
// arrive while o_ready=0 are dropped, not queued. Rejected requests, meaning an
// enqueue into a full queue or a dequeue from an empty one, leave the contents
// untouched and raise o_overflow/o_underflow for one cycle.
module param_heap_pq #(
  parameter int QUEUE_SIZE    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int PAYLOAD_WIDTH = 8,
  parameter int MAX_FIRST     = 1
) (
  input  logic                            CLK,
  input  logic                            RSTn,
  input  logic                            i_wrt,
  input  logic                            i_read,
  input  logic [DATA_WIDTH-1:0]           i_data,
  input  logic [PAYLOAD_WIDTH-1:0]        i_payload,
  output logic                            o_ready,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic [PAYLOAD_WIDTH-1:0]        o_payload,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
  output logic                            o_overflow,
  output logic                            o_underflow,
  output logic [1:0]                      o_state
);

  localparam int IW = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
  localparam int CW = $clog2(QUEUE_SIZE + 1);
  // Child indices can reach 2*(QUEUE_SIZE-1)+2, so they need one extra bit.
  localparam int XW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SIFT_UP   = 2'd1,
    S_SIFT_DOWN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    key;
    logic [PAYLOAD_WIDTH-1:0] pl;
  } entry_t;

  entry_t        heap [QUEUE_SIZE];
  logic [CW-1:0] count;
  logic [IW-1:0] idx;
  state_t        state, state_nxt;

  // Strict comparison. Equal keys are never "better", so equal keys never swap.
  function automatic logic better(input logic [DATA_WIDTH-1:0] a,
                                  input logic [DATA_WIDTH-1:0] b);
    if (MAX_FIRST != 0) return a > b;
    else                return a < b;
  endfunction

  logic          full, empty;
  logic          idle;
  logic [CW-1:0] cnt_m1;
  logic [IW-1:0] last_i, parent_i, left_i, right_i, sel_i;
  logic [XW-1:0] left_w, right_w;
  logic          left_ok, right_ok, pick_right;
  logic          swap_up, swap_down;
  entry_t        cur_e, par_e, l_e, r_e, sel_e, new_e;
  logic          acc_enq, acc_deq, acc_rep, rej_ovf, rej_unf;

  assign full     = (count == CW'(QUEUE_SIZE));
  assign empty    = (count == '0);
  assign idle     = (state == S_IDLE);
  assign cnt_m1   = count - CW'(1);
  assign last_i   = cnt_m1[IW-1:0];
  assign new_e    = '{key: i_data, pl: i_payload};

  // Neighbourhood of the moving node.
  assign parent_i = IW'((idx - IW'(1)) >> 1);
  assign left_w   = XW'({idx, 1'b1});
  assign right_w  = left_w + XW'(1);
  assign left_ok  = (left_w < XW'(count));
  assign right_ok = (right_w < XW'(count));
  assign left_i   = left_w[IW-1:0];
  assign right_i  = right_w[IW-1:0];

  assign cur_e    = heap[idx];
  assign par_e    = heap[parent_i];
  assign l_e      = heap[left_i];
  assign r_e      = heap[right_i];

  // On a tie between the two children, the left child is chosen.
  assign pick_right = right_ok && better(r_e.key, l_e.key);
  assign sel_i      = pick_right ? right_i : left_i;
  assign sel_e      = pick_right ? r_e : l_e;
  assign swap_down  = left_ok && better(sel_e.key, cur_e.key);
  assign swap_up    = (idx != '0) && better(cur_e.key, par_e.key);

  // Request decode. A replace into an empty queue is treated as an enqueue.
  assign acc_enq = idle && i_wrt && (!i_read || empty) && !full;
  assign acc_deq = idle && !i_wrt && i_read && !empty;
  assign acc_rep = idle && i_wrt && i_read && !empty;
  assign rej_ovf = idle && i_wrt && !i_read && full;
  assign rej_unf = idle && !i_wrt && i_read && empty;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and ready decode.
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    unique case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (acc_enq)                state_nxt = S_SIFT_UP;
        else if (acc_deq || acc_rep) state_nxt = S_SIFT_DOWN;
      end
      S_SIFT_UP:   if (!swap_up)   state_nxt = S_IDLE;
      S_SIFT_DOWN: if (!swap_down) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Heap storage, occupancy, moving index and flag pulses.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int i = 0; i < QUEUE_SIZE; i++) heap[i] <= '0;
      count       <= '0;
      idx         <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= rej_ovf;
      o_underflow <= rej_unf;
      if (acc_enq) begin
        heap[count[IW-1:0]] <= new_e;
        count               <= count + CW'(1);
        idx                 <= count[IW-1:0];
      end else if (acc_deq) begin
        heap[0] <= heap[last_i];
        count   <= cnt_m1;
        idx     <= '0;
      end else if (acc_rep) begin
        heap[0] <= new_e;
        idx     <= '0;
      end else if (state == S_SIFT_UP && swap_up) begin
        heap[idx]      <= par_e;
        heap[parent_i] <= cur_e;
        idx            <= parent_i;
      end else if (state == S_SIFT_DOWN && swap_down) begin
        heap[idx]   <= sel_e;
        heap[sel_i] <= cur_e;
        idx         <= sel_i;
      end
    end
  end

  assign o_full    = full;
  assign o_empty   = empty;
  assign o_count   = count;
  assign o_data    = heap[0].key;
  assign o_payload = heap[0].pl;
  assign o_state   = state;

endmodule

// File: tb/tb_param_heap_pq.sv
// tb_param_heap_pq: directed and randomized checks of param_heap_pq in both
// ordering modes, using a multiset reference model held in a queue.
module tb_param_heap_pq;

  localparam int QS = 16;
  localparam int DW = 16;
  localparam int PW = 8;
  localparam int CW = $clog2(QS + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          drv_wrt, drv_read, sel_min;
  logic [DW-1:0] drv_data;
  logic [PW-1:0] drv_pl;

  logic          mx_ready, mx_full, mx_empty, mx_ovf, mx_unf;
  logic [DW-1:0] mx_data;
  logic [PW-1:0] mx_pl;
  logic [CW-1:0] mx_count;
  logic [1:0]    mx_state;
  logic          mn_ready, mn_full, mn_empty, mn_ovf, mn_unf;
  logic [DW-1:0] mn_data;
  logic [PW-1:0] mn_pl;
  logic [CW-1:0] mn_count;
  logic [1:0]    mn_state;

  param_heap_pq #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW), .MAX_FIRST(1)) dut_max (
    .CLK(clk), .RSTn(rstn),
    .i_wrt(drv_wrt & ~sel_min), .i_read(drv_read & ~sel_min),
    .i_data(drv_data), .i_payload(drv_pl),
    .o_ready(mx_ready), .o_full(mx_full), .o_empty(mx_empty),
    .o_data(mx_data), .o_payload(mx_pl), .o_count(mx_count),
    .o_overflow(mx_ovf), .o_underflow(mx_unf), .o_state(mx_state)
  );

  param_heap_pq #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW), .MAX_FIRST(0)) dut_min (
    .CLK(clk), .RSTn(rstn),
    .i_wrt(drv_wrt & sel_min), .i_read(drv_read & sel_min),
    .i_data(drv_data), .i_payload(drv_pl),
    .o_ready(mn_ready), .o_full(mn_full), .o_empty(mn_empty),
    .o_data(mn_data), .o_payload(mn_pl), .o_count(mn_count),
    .o_overflow(mn_ovf), .o_underflow(mn_unf), .o_state(mn_state)
  );

  // Observed signals of whichever queue is currently selected.
  logic          ready, full, empty, ovf, unf;
  logic [DW-1:0] data;
  logic [PW-1:0] pl;
  logic [CW-1:0] count;
  assign ready = sel_min ? mn_ready : mx_ready;
  assign full  = sel_min ? mn_full  : mx_full;
  assign empty = sel_min ? mn_empty : mx_empty;
  assign ovf   = sel_min ? mn_ovf   : mx_ovf;
  assign unf   = sel_min ? mn_unf   : mx_unf;
  assign data  = sel_min ? mn_data  : mx_data;
  assign pl    = sel_min ? mn_pl    : mx_pl;
  assign count = sel_min ? mn_count : mx_count;

  // ---------------- scoreboard ----------------
  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Payloads are a pure function of the key, so duplicate keys are unambiguous.
  function automatic logic [PW-1:0] pl_of(input logic [DW-1:0] k);
    return k[7:0] ^ k[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [DW-1:0] model_best();
    logic [DW-1:0] b;
    b = '0;
    if (exp_q.size() > 0) b = exp_q[0];
    foreach (exp_q[i])
      if (sel_min ? (exp_q[i] < b) : (exp_q[i] > b)) b = exp_q[i];
    return b;
  endfunction

  task automatic model_remove_best();
    logic [DW-1:0] b;
    int pos;
    b = model_best();
    pos = -1;
    foreach (exp_q[i]) if (pos < 0 && exp_q[i] == b) pos = i;
    if (pos >= 0) exp_q.delete(pos);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic r, input logic [DW-1:0] k);
    drv_wrt  = w;
    drv_read = r;
    drv_data = k;
    drv_pl   = pl_of(k);
    tick();
    drv_wrt  = 1'b0;
    drv_read = 1'b0;
  endtask

  task automatic wait_ready(output int busy);
    busy = 0;
    while (!ready && busy < 20) begin
      busy++;
      tick();
    end
    if (!ready) check("ready_timeout", ready, 1);
  endtask

  task automatic check_root(input string tag);
    check({tag, "_data"}, data, model_best());
    check({tag, "_payload"}, pl, pl_of(model_best()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy;
    logic [DW-1:0] k;
    int min_keys[5];
    int min_roots[5];
    int min_out[5];
    min_keys  = '{5, 3, 9, 3, 1};
    min_roots = '{5, 3, 3, 3, 1};
    min_out   = '{1, 3, 3, 5, 9};

    rstn = 1'b0; drv_wrt = 1'b0; drv_read = 1'b0; drv_data = '0; drv_pl = '0; sel_min = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;

    // Reset state.
    check("rst_ready", mx_ready, 1);
    check("rst_empty", mx_empty, 1);
    check("rst_full", mx_full, 0);
    check("rst_count", mx_count, 0);
    check("rst_data", mx_data, 0);
    check("rst_payload", mx_pl, 0);
    check("rst_ovf", mx_ovf, 0);
    check("rst_unf", mx_unf, 0);
    check("rst_min_empty", mn_empty, 1);
    check("rst_min_data", mn_data, 0);

    // Dequeue from empty.
    issue(1'b0, 1'b1, '0);
    check("unf_pulse", unf, 1);
    check("unf_count", count, 0);
    check("unf_ready", ready, 1);
    tick();
    check("unf_clear", unf, 0);

    // Fill in max mode.
    for (int i = 0; i < QS; i++) begin
      k = DW'($urandom_range(0, 1024));
      issue(1'b1, 1'b0, k);
      exp_q.push_back(k);
      check("fill_count", count, i + 1);
      wait_ready(busy);
      check("fill_busy", busy <= 5, 1);
      check_root("fill");
    end
    check("fill_full", full, 1);

    // Overflow.
    issue(1'b1, 1'b0, 16'd1000);
    check("ovf_pulse", ovf, 1);
    check("ovf_full", full, 1);
    check("ovf_count", count, QS);
    check("ovf_ready", ready, 1);
    check_root("ovf");
    tick();
    check("ovf_clear", ovf, 0);
    check("ovf_count2", count, QS);

    // Drain: root sequence must follow the model.
    for (int i = 0; i < QS; i++) begin
      check_root("drain");
      issue(1'b0, 1'b1, '0);
      model_remove_best();
      check("drain_count", count, exp_q.size());
      wait_ready(busy);
      check("drain_busy", busy <= 5, 1);
    end
    check("drain_empty", empty, 1);

    // Replace stress.
    for (int i = 0; i < QS; i++) begin
      k = DW'($urandom_range(0, 1024));
      issue(1'b1, 1'b0, k);
      exp_q.push_back(k);
      wait_ready(busy);
    end
    check_root("refill");
    for (int i = 0; i < 20; i++) begin
      k = DW'($urandom_range(0, 1024));
      issue(1'b1, 1'b1, k);
      model_remove_best();
      exp_q.push_back(k);
      check("rep_count", count, QS);
      wait_ready(busy);
      check("rep_busy", busy <= 5, 1);
      check_root("rep");
    end

    // Min mode on the second queue.
    sel_min = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1'b0, DW'(min_keys[i]));
      exp_q.push_back(DW'(min_keys[i]));
      wait_ready(busy);
      check("min_root", data, min_roots[i]);
      check_root("min_ins");
    end
    for (int i = 0; i < 5; i++) begin
      check("min_out", data, min_out[i]);
      check("min_out_payload", pl, pl_of(DW'(min_out[i])));
      issue(1'b0, 1'b1, '0);
      model_remove_best();
      wait_ready(busy);
    end
    check("min_empty", empty, 1);

    // Reset in the middle of a sift-up.
    sel_min = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    exp_q.delete();
    for (int i = 0; i < QS - 1; i++) begin
      k = DW'($urandom_range(0, 1024));
      issue(1'b1, 1'b0, k);
      exp_q.push_back(k);
      wait_ready(busy);
    end
    check("pre_mid_count", count, QS - 1);
    issue(1'b1, 1'b0, 16'd2000);
    check("mid_busy1", ready, 0);
    tick();
    check("mid_busy2", ready, 0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    exp_q.delete();
    check("mid_rst_count", count, 0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_data", data, 0);
    check("mid_rst_empty", empty, 1);
    issue(1'b1, 1'b0, 16'd7);
    exp_q.push_back(16'd7);
    wait_ready(busy);
    check("post_rst_data", data, 7);
    check("post_rst_count", count, 1);
    check_root("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
